// File: rtl/axi2ahb_wdata_burst.sv
// axi2ahb_wdata_burst
//   AXI-to-AHB bridge write data path, one burst at a time.
//   Accepts a write command from the bridge control FSM, buffers the W beats
//   of that burst, offers each beat for an AHB address phase, drives HWDATA
//   in the matching data phase, and queues one B response per burst.
//
// Ports
//   ACLK, ARESET                 clock, synchronous active-high reset
//   WDATA/WSTRB/WLAST/WVALID     AXI W channel in, WREADY out
//   BID/BRESP/BVALID, BREADY     AXI B channel out (from response FIFO)
//   HWDATA, HREADY, HRESP        AHB data phase
//   cmd_valid_i/cmd_ready_o      write command handshake (id, len, error)
//   beat_valid_o/beat_last_o     buffered beat offered to the control FSM
//   beat_ready_i                 control FSM issued the address phase
//
// state  | meaning
// IDLE   | waiting for a command; accepts only when the response FIFO has room
// BEATS  | moving W beats through the 1-entry buffer to AHB
// LASTDP | last beat issued; waiting for its data phase to finish
// DRAIN  | bad command; swallow W beats, then respond DECERR

module axi2ahb_wdata_burst #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int RESP_DEPTH     = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [AXI_DATA_WIDTH-1:0]   HWDATA,
  input  logic                        HREADY,
  input  logic                        HRESP,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     cmd_id_i,
  input  logic [7:0]                  cmd_len_i,
  input  logic                        cmd_error_i,
  output logic                        beat_valid_o,
  output logic                        beat_last_o,
  input  logic                        beat_ready_i
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int EW = AXI_ID_WIDTH + 2;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BEATS, S_LASTDP, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic                      all_acc_q;
  logic                      slverr_q;
  logic                      buf_full_q;
  logic                      buf_last_q;
  logic [AXI_DATA_WIDTH-1:0] buf_data_q;
  logic [AXI_DATA_WIDTH-1:0] hwdata_q;
  logic                      dp_active_q;

  logic [EW-1:0] fifo_mem_q [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   fifo_cnt_q;
  logic          fifo_full;

  logic          push;
  logic [1:0]    push_resp;
  logic          pop;
  logic          w_acc;
  logic          handoff;
  logic          cmd_acc;
  logic          last_idx;
  logic          slverr_now;

  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign w_acc      = WVALID && WREADY;
  assign handoff    = beat_valid_o && beat_ready_i;
  assign cmd_acc    = cmd_valid_i && cmd_ready_o;
  assign last_idx   = (cnt_q == len_q);
  // HRESP in the completing cycle of the last data phase still counts.
  assign slverr_now = slverr_q || (dp_active_q && HRESP);

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    WREADY       = 1'b0;
    cmd_ready_o  = 1'b0;
    beat_valid_o = 1'b0;
    beat_last_o  = 1'b0;
    push         = 1'b0;
    push_resp    = RESP_OKAY;
    case (state_q)
      S_IDLE: begin
        // Held low during reset so the reset-time outputs are all quiet.
        cmd_ready_o = !fifo_full && !ARESET;
        if (cmd_valid_i && cmd_ready_o)
          state_d = cmd_error_i ? S_DRAIN : S_BEATS;
      end
      S_BEATS: begin
        beat_valid_o = buf_full_q;
        beat_last_o  = buf_full_q && buf_last_q;
        // Stop taking W once the len+1'th beat is in, whatever WLAST said.
        WREADY = !all_acc_q && (!buf_full_q || beat_ready_i);
        if (buf_full_q && beat_ready_i && buf_last_q)
          state_d = S_LASTDP;
      end
      S_LASTDP: begin
        if (HREADY) begin
          push      = 1'b1;
          push_resp = slverr_now ? RESP_SLVERR : RESP_OKAY;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        WREADY = 1'b1;
        if (WVALID && last_idx) begin
          push      = 1'b1;
          push_resp = RESP_DECERR;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      all_acc_q   <= 1'b0;
      slverr_q    <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_data_q  <= '0;
      hwdata_q    <= '0;
      dp_active_q <= 1'b0;
    end else begin
      if (cmd_acc) begin
        id_q      <= cmd_id_i;
        len_q     <= cmd_len_i;
        cnt_q     <= '0;
        all_acc_q <= 1'b0;
        slverr_q  <= 1'b0;
      end else begin
        if (w_acc) begin
          cnt_q <= cnt_q + 8'd1;
          if (last_idx) all_acc_q <= 1'b1;
          if ((WSTRB != '1) || (WLAST != last_idx)) slverr_q <= 1'b1;
        end
        if (dp_active_q && HRESP) slverr_q <= 1'b1;
      end

      if (w_acc && (state_q == S_BEATS)) begin
        buf_full_q <= 1'b1;
        buf_data_q <= WDATA;
        buf_last_q <= last_idx;
      end else if (handoff) begin
        buf_full_q <= 1'b0;
      end

      // beat_ready_i implies HREADY, so the previous data phase ends on a hand-off.
      if (handoff) begin
        hwdata_q    <= buf_data_q;
        dp_active_q <= 1'b1;
      end else if (HREADY) begin
        dp_active_q <= 1'b0;
      end
    end
  end

  assign HWDATA = hwdata_q;

  assign BVALID = (fifo_cnt_q != '0);
  assign pop    = BVALID && BREADY;
  assign BID    = fifo_mem_q[rd_ptr_q][EW-1:2];
  assign BRESP  = fifo_mem_q[rd_ptr_q][1:0];

  always_ff @(posedge ACLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {id_q, push_resp};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
